ddr_region_loader: RTL and testbench

Synthesizable, parametrised DDR preload engine. It writes a configuration block, then streams up to `NUM_REGION` data regions (activations, activation flags, weights, weight flags, and further regions) from a word-wide input stream into a byte-lane memory write port. Each word is split into `DATA_WIDTH` lanes, written LSB lane first. It sits between the host/DMA input stream and the DDR model/controller write side of the mem_controller subsystem.

---
 rtl/dw_loader_pkg.sv | 44 ++++
 rtl/ddr_region_loader_lane_serializer.sv | 44 ++++
 rtl/ddr_region_loader.sv | 179 +++++++++++++++++
 tb/tb_ddr_region_loader.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dw_loader_pkg.sv
// Shared types and helpers for the DDR region preload engine.
// Holds the FSM state encoding, lane-count derivation and packed-bus field slicing.
package dw_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_SEL,
    ST_LOAD,
    ST_DONE
  } state_t;

  // Widest packed region bus the slice helpers accept.
  localparam int unsigned MAX_BUS = 2048;

  function automatic int unsigned calc_lanes(input int unsigned port_w,
                                             input int unsigned data_w);
    return port_w / data_w;
  endfunction

  function automatic logic [63:0] bus_field(input logic [MAX_BUS-1:0] bus,
                                            input int unsigned idx,
                                            input int unsigned w);
    logic [MAX_BUS-1:0] sh;
    logic [63:0]        mask;
    sh = bus >> (idx * w);
    if (w >= 64) mask = '1;
    else         mask = (64'd1 << w) - 64'd1;
    return sh[63:0] & mask;
  endfunction

  function automatic logic [63:0] region_base_at(input logic [MAX_BUS-1:0] bus,
                                                 input int unsigned r,
                                                 input int unsigned addr_w);
    return bus_field(bus, r, addr_w);
  endfunction

  function automatic logic [63:0] region_len_at(input logic [MAX_BUS-1:0] bus,
                                                input int unsigned r,
                                                input int unsigned len_w);
    return bus_field(bus, r, len_w);
  endfunction

endpackage

// File: rtl/ddr_region_loader_lane_serializer.sv
// Splits one input word into LSB-first memory lanes under a valid/ready handshake.
// Outputs come straight from registers, so they hold steady while the sink stalls.
module lane_serializer
  import dw_loader_pkg::*;
#(
  parameter int unsigned PORT_DATAWIDTH = 64,
  parameter int unsigned DATA_WIDTH     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [PORT_DATAWIDTH-1:0] word,
  output logic                      lane_valid,
  input  logic                      lane_ready,
  output logic [DATA_WIDTH-1:0]     lane_data,
  output logic                      empty,
  output logic                      last_lane
);

  localparam int unsigned LANES = calc_lanes(PORT_DATAWIDTH, DATA_WIDTH);
  localparam int unsigned CW    = $clog2(LANES + 1);

  logic [PORT_DATAWIDTH-1:0] sh;
  logic [CW-1:0]             left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      left <= '0;
    end else if (load && empty) begin
      sh   <= word;
      left <= CW'(LANES);
    end else if (lane_valid && lane_ready) begin
      sh   <= sh >> DATA_WIDTH;
      left <= left - CW'(1);
    end
  end

  assign lane_valid = (left != '0);
  assign lane_data  = sh[DATA_WIDTH-1:0];
  assign empty      = (left == '0);
  assign last_lane  = (left == CW'(1));

endmodule

// File: rtl/ddr_region_loader.sv
// DDR preload engine: writes a config block, then streams each enabled region
// from the input word stream into the byte-lane memory write port.
module ddr_region_loader
  import dw_loader_pkg::*;
#(
  parameter int unsigned           PORT_DATAWIDTH = 64,
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           NUM_REGION     = 4,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           LEN_WIDTH      = 20,
  parameter int unsigned           CFG_WORDS      = 256,
  parameter logic [ADDR_WIDTH-1:0] DDR_OFFSET     = 'h0800_0000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            cfg_addr,
  input  logic [PORT_DATAWIDTH-1:0]        cfg_word,
  input  logic [NUM_REGION*ADDR_WIDTH-1:0] region_base,
  input  logic [NUM_REGION*LEN_WIDTH-1:0]  region_len,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [PORT_DATAWIDTH-1:0]        in_data,
  output logic                             mem_wr_en,
  input  logic                             mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]            mem_wr_addr,
  output logic [DATA_WIDTH-1:0]            mem_wr_data,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(NUM_REGION):0]      cur_region,
  output logic                             err_addr
);

  localparam int unsigned RW   = $clog2(NUM_REGION) + 1;
  localparam int unsigned CNTW = $clog2(CFG_WORDS + 1);

  state_t                          state, state_n;
  logic [RW-1:0]                   r;
  logic [ADDR_WIDTH-1:0]           addr;
  logic [LEN_WIDTH-1:0]            wcnt;
  logic [CNTW-1:0]                 cfg_cnt;
  logic [NUM_REGION*ADDR_WIDTH-1:0] base_q;
  logic [NUM_REGION*LEN_WIDTH-1:0]  len_q;
  logic                            err_q;

  logic                      ser_load, ser_valid, ser_empty, ser_last;
  logic [PORT_DATAWIDTH-1:0] ser_word;
  logic [DATA_WIDTH-1:0]     ser_data;
  logic                      lane_fire;
  logic                      take_start, cfg_exit, adv_r, set_err, enter_load, accept;
  logic [ADDR_WIDTH-1:0]     cur_base;
  logic [LEN_WIDTH-1:0]      cur_len;
  logic                      r_last;

  assign cur_base  = ADDR_WIDTH'(region_base_at(MAX_BUS'(base_q), 32'(r), ADDR_WIDTH));
  assign cur_len   = LEN_WIDTH'(region_len_at(MAX_BUS'(len_q), 32'(r), LEN_WIDTH));
  assign r_last    = (r == RW'(NUM_REGION - 1));
  assign lane_fire = ser_valid && mem_wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Leaving the final region jumps straight to DONE so done follows the last lane by one cycle.
  always_comb begin
    state_n    = state;
    ser_load   = 1'b0;
    ser_word   = '0;
    take_start = 1'b0;
    cfg_exit   = 1'b0;
    adv_r      = 1'b0;
    set_err    = 1'b0;
    enter_load = 1'b0;
    accept     = 1'b0;
    in_ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          take_start = 1'b1;
          ser_load   = 1'b1;
          ser_word   = cfg_word;
          state_n    = ST_CFG;
        end
      end
      ST_CFG: begin
        if (ser_empty && (cfg_cnt < CNTW'(CFG_WORDS))) ser_load = 1'b1;
        if (lane_fire && ser_last && (cfg_cnt == CNTW'(CFG_WORDS))) begin
          cfg_exit = 1'b1;
          state_n  = ST_SEL;
        end
      end
      ST_SEL: begin
        if (r >= RW'(NUM_REGION)) begin
          state_n = ST_DONE;
        end else if (cur_len == '0) begin
          adv_r = 1'b1;
          if (r_last) state_n = ST_DONE;
        end else if (cur_base < DDR_OFFSET) begin
          adv_r   = 1'b1;
          set_err = 1'b1;
          if (r_last) state_n = ST_DONE;
        end else begin
          enter_load = 1'b1;
          state_n    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = ser_empty && (wcnt != '0);
        if (in_valid && in_ready) begin
          accept   = 1'b1;
          ser_load = 1'b1;
          ser_word = in_data;
        end
        if (lane_fire && ser_last && (wcnt == '0)) begin
          adv_r   = 1'b1;
          state_n = r_last ? ST_DONE : ST_SEL;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r       <= '0;
      addr    <= '0;
      wcnt    <= '0;
      cfg_cnt <= '0;
      base_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else if (take_start) begin
      base_q  <= region_base;
      len_q   <= region_len;
      addr    <= cfg_addr - DDR_OFFSET;
      cfg_cnt <= CNTW'(1);
      r       <= RW'(NUM_REGION);
      err_q   <= 1'b0;
    end else begin
      if ((state == ST_CFG) && ser_load) cfg_cnt <= cfg_cnt + CNTW'(1);
      if (cfg_exit) r <= '0;
      if (adv_r)    r <= r + RW'(1);
      if (set_err)  err_q <= 1'b1;
      if (enter_load) begin
        addr <= cur_base - DDR_OFFSET;
        wcnt <= cur_len;
      end else if (lane_fire) begin
        addr <= addr + ADDR_WIDTH'(1);
      end
      if (accept) wcnt <= wcnt - LEN_WIDTH'(1);
    end
  end

  lane_serializer #(
    .PORT_DATAWIDTH(PORT_DATAWIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (ser_load),
    .word      (ser_word),
    .lane_valid(ser_valid),
    .lane_ready(mem_wr_ready),
    .lane_data (ser_data),
    .empty     (ser_empty),
    .last_lane (ser_last)
  );

  assign mem_wr_en   = ser_valid;
  assign mem_wr_addr = addr;
  assign mem_wr_data = ser_data;
  assign busy        = (state == ST_CFG) || (state == ST_SEL) || (state == ST_LOAD);
  assign done        = (state == ST_DONE);
  assign cur_region  = r;
  assign err_addr    = err_q;

endmodule

// File: tb/tb_ddr_region_loader.sv
// Directed bench for ddr_region_loader: config block, region loads, skips,
// stalled memory port, mid-load reset and start while busy.
module tb_ddr_region_loader;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 20;

  logic          clk, rst_n, start;
  logic [31:0]   cfg_addr;
  logic [63:0]   cfg_word;
  logic [NR*AW-1:0] region_base;
  logic [NR*LW-1:0] region_len;
  logic          in_valid, in_ready;
  logic [63:0]   in_data;
  logic          mem_wr_en, mem_wr_ready;
  logic [31:0]   mem_wr_addr;
  logic [7:0]    mem_wr_data;
  logic          busy, done, err_addr;
  logic [2:0]    cur_region;

  ddr_region_loader #(
    .PORT_DATAWIDTH(64),
    .DATA_WIDTH    (8),
    .NUM_REGION    (NR),
    .ADDR_WIDTH    (AW),
    .LEN_WIDTH     (LW),
    .CFG_WORDS     (256),
    .DDR_OFFSET    (32'h0800_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_addr(cfg_addr), .cfg_word(cfg_word),
    .region_base(region_base), .region_len(region_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_wr_en(mem_wr_en), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .cur_region(cur_region), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] CW = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W0 = 64'h1122_3344_5566_7788;
  localparam logic [63:0] W1 = 64'h99AA_BBCC_DDEE_FF00;
  localparam logic [63:0] W2 = 64'h0F1E_2D3C_4B5A_6978;
  localparam logic [63:0] W3 = 64'hDEAD_BEEF_CAFE_F00D;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem   [int unsigned];
  int          wc    [int unsigned];
  int          wr_at [int unsigned];
  logic [63:0] inq[$];
  logic [63:0] expw[$];
  int          acc_iters[$];
  int          trace[$];
  int n_wr, n_hs, n_rdy, done_cnt, done_iter, last_wr_iter, first_en_iter, stall_bad, ready_bad;
  logic err_at0, busy_at0;

  function automatic logic [7:0] rd(input int unsigned a);
    if (mem.exists(a)) return mem[a];
    return 8'hxx;
  endfunction

  function automatic int bad_bytes(input int unsigned a0, input int first, input int nw);
    int bad = 0;
    logic [63:0] w;
    for (int i = 0; i < nw; i++) begin
      w = expw[first + i];
      for (int l = 0; l < 8; l++)
        if (rd(a0 + 32'(i * 8 + l)) !== w[l*8 +: 8]) bad++;
    end
    return bad;
  endfunction

  function automatic int cfg_bad(input logic [63:0] cw);
    int bad = 0;
    logic [7:0] e;
    for (int i = 0; i < 2048; i++) begin
      e = (i < 8) ? cw[i*8 +: 8] : 8'h00;
      if (rd(32'(i)) !== e) bad++;
    end
    return bad;
  endfunction

  function automatic int dup_count();
    int d = 0;
    foreach (wc[a]) if (wc[a] != 1) d++;
    return d;
  endfunction

  task automatic set_region(input int r, input logic [31:0] b, input logic [19:0] l);
    region_base[r*AW +: AW] = b;
    region_len[r*LW +: LW]  = l;
  endtask

  task automatic run_job(input bit rnd, input int busy_iter, input int abort_hs);
    bit acc, prev_stall, fin;
    logic [31:0] pa;
    logic [7:0]  pd;
    n_wr = 0; n_hs = 0; n_rdy = 0; done_cnt = 0; done_iter = -1; last_wr_iter = -1;
    first_en_iter = -1; stall_bad = 0; ready_bad = 0;
    mem.delete(); wc.delete(); wr_at.delete(); acc_iters.delete(); trace.delete();
    mem_wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    in_valid = (inq.size() > 0);
    in_data  = in_valid ? inq[0] : '0;
    @(posedge clk); #1 start = 1'b1;
    acc = 1'b0; prev_stall = 1'b0; fin = 1'b0; pa = '0; pd = '0;
    for (int cyc = 0; cyc < 10000 && !fin; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == busy_iter);
      if (cyc == busy_iter) begin
        cfg_word    = ~cfg_word;
        region_base = ~region_base;
        region_len  = ~region_len;
      end
      if (acc) void'(inq.pop_front());
      in_valid = (inq.size() > 0);
      in_data  = in_valid ? inq[0] : '0;
      if (rnd) mem_wr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cyc == 0) begin err_at0 = err_addr; busy_at0 = busy; end
      if (mem_wr_en && first_en_iter < 0) first_en_iter = cyc;
      if (prev_stall && (!mem_wr_en || mem_wr_addr !== pa || mem_wr_data !== pd)) stall_bad++;
      prev_stall = mem_wr_en && !mem_wr_ready;
      pa = mem_wr_addr; pd = mem_wr_data;
      if (mem_wr_en && mem_wr_ready) begin
        mem[mem_wr_addr]   = mem_wr_data;
        wc[mem_wr_addr]    = wc.exists(mem_wr_addr) ? wc[mem_wr_addr] + 1 : 1;
        wr_at[mem_wr_addr] = cyc;
        last_wr_iter = cyc;
        n_wr++;
      end
      if (in_ready) begin
        n_rdy++;
        if (mem_wr_en) ready_bad++;
      end
      acc = in_valid && in_ready;
      if (acc) begin n_hs++; acc_iters.push_back(cyc); end
      if (busy && (trace.size() == 0 || trace[$] != int'(cur_region))) trace.push_back(int'(cur_region));
      if (done) begin done_cnt++; if (done_iter < 0) done_iter = cyc; end
      if (done_iter >= 0 && cyc >= done_iter + 4) fin = 1'b1;
      if (abort_hs > 0 && n_hs >= abort_hs) fin = 1'b1;
    end
    if (abort_hs == 0) begin
      checks++;
      if (done_iter < 0) begin
        errors++;
        $display("FAIL job_timeout: done never seen, required within 10000 cycles");
      end
    end
  endtask

  task automatic config_skip();
    cfg_addr = 32'h0800_0000; cfg_word = CW;
    set_region(0, 32'h0810_0000, 20'd2);
    set_region(1, 32'h0900_0000, 20'd0);
    set_region(2, 32'h0700_0000, 20'd5);
    set_region(3, 32'h0820_0010, 20'd2);
    expw.delete(); expw = '{W0, W1, W2, W3};
    inq.delete();  inq  = '{W0, W1, W2, W3};
  endtask

  task automatic config_region0();
    cfg_addr = 32'h0800_0000; cfg_word = CW;
    region_base = '0; region_len = '0;
    set_region(0, 32'h0810_0000, 20'd3);
    expw.delete(); expw = '{W0, W1, W2};
    inq.delete();  inq  = '{W0, W1, W2};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_wr_ready = 1'b1;
    cfg_addr = '0; cfg_word = '0; region_base = '0; region_len = '0;
    #12;
    checks++;
    if ({in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, cur_region, err_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h busy=%b done=%b cur=%0d err=%b rdy=%b, required all 0",
               mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, cur_region, err_addr, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_cfg_only();
    cfg_addr = 32'h0800_0000; cfg_word = CW; region_base = '0; region_len = '0;
    inq.delete();
    run_job(1'b0, -1, 0);
    checks++; if (first_en_iter !== 0) begin errors++; $display("FAIL cfg_first_en: got cycle %0d, required 0", first_en_iter); end
    checks++; if (busy_at0 !== 1'b1) begin errors++; $display("FAIL cfg_busy: got %b, required 1", busy_at0); end
    checks++; if (rd(0) !== 8'hEF) begin errors++; $display("FAIL cfg_addr0: got %h, required ef", rd(0)); end
    checks++; if (rd(7) !== 8'h01) begin errors++; $display("FAIL cfg_addr7: got %h, required 01", rd(7)); end
    checks++; if (cfg_bad(CW) != 0) begin errors++; $display("FAIL cfg_block: got %0d bad bytes, required 0", cfg_bad(CW)); end
    checks++; if (n_wr != 2048) begin errors++; $display("FAIL cfg_writes: got %0d, required 2048", n_wr); end
    checks++; if (dup_count() != 0) begin errors++; $display("FAIL cfg_dups: got %0d, required 0", dup_count()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL cfg_done: got %0d pulses, required 1", done_cnt); end
    checks++; if (n_rdy != 0) begin errors++; $display("FAIL cfg_in_ready: got %0d cycles, required 0", n_rdy); end
    checks++; if (trace.size() == 0 || trace[0] != 4) begin errors++; $display("FAIL cfg_cur_region: got %0d entries, required first value 4", trace.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_region_load();
    config_region0();
    run_job(1'b0, -1, 0);
    checks++; if (bad_bytes(32'h0010_0000, 0, 3) != 0) begin errors++; $display("FAIL r0_data: got %0d bad bytes, required 0", bad_bytes(32'h0010_0000, 0, 3)); end
    checks++; if (rd(32'h0010_0000) !== 8'h88) begin errors++; $display("FAIL r0_first: got %h, required 88", rd(32'h0010_0000)); end
    checks++; if (rd(32'h0010_0017) !== 8'h0F) begin errors++; $display("FAIL r0_last: got %h, required 0f", rd(32'h0010_0017)); end
    checks++; if (n_hs != 3) begin errors++; $display("FAIL r0_handshakes: got %0d, required 3", n_hs); end
    checks++; if (n_wr != 2072) begin errors++; $display("FAIL r0_writes: got %0d, required 2072", n_wr); end
    checks++; if (dup_count() != 0) begin errors++; $display("FAIL r0_dups: got %0d, required 0", dup_count()); end
    checks++;
    if (acc_iters.size() != 3 || acc_iters[1] - acc_iters[0] != 9 || acc_iters[2] - acc_iters[1] != 9) begin
      errors++; $display("FAIL r0_word_period: got %0d accepts not 9 cycles apart, required period 9", acc_iters.size());
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL r0_done: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_skip_err();
    config_skip();
    run_job(1'b0, -1, 0);
    checks++; if (err_addr !== 1'b1) begin errors++; $display("FAIL skip_err: got %b, required 1", err_addr); end
    checks++; if (bad_bytes(32'h0010_0000, 0, 2) != 0) begin errors++; $display("FAIL skip_r0_data: got %0d bad, required 0", bad_bytes(32'h0010_0000, 0, 2)); end
    checks++; if (bad_bytes(32'h0020_0010, 2, 2) != 0) begin errors++; $display("FAIL skip_r3_data: got %0d bad, required 0", bad_bytes(32'h0020_0010, 2, 2)); end
    checks++; if (n_hs != 4) begin errors++; $display("FAIL skip_handshakes: got %0d, required 4", n_hs); end
    checks++; if (n_wr != 2080) begin errors++; $display("FAIL skip_writes: got %0d, required 2080", n_wr); end
    checks++;
    if (trace.size() != 5 || trace[0] != 4 || trace[1] != 0 || trace[2] != 1 || trace[3] != 2 || trace[4] != 3) begin
      errors++; $display("FAIL skip_cur_region: got %0d distinct values, required sequence 4,0,1,2,3", trace.size());
    end
    checks++; if (done_iter != last_wr_iter + 1) begin errors++; $display("FAIL skip_done_latency: got %0d, required %0d", done_iter, last_wr_iter + 1); end
    checks++;
    if (acc_iters.size() < 3 || !wr_at.exists(32'h0010_000F) || acc_iters[2] - wr_at[32'h0010_000F] != 4) begin
      errors++; $display("FAIL skip_sel_cycles: got %0d accepts, required region 3 accept 4 cycles after region 0 end", acc_iters.size());
    end
    checks++; if (dup_count() != 0) begin errors++; $display("FAIL skip_dups: got %0d, required 0", dup_count()); end
  endtask

  task automatic test_random_ready();
    config_skip();
    run_job(1'b1, -1, 0);
    checks++; if (err_at0 !== 1'b0) begin errors++; $display("FAIL rnd_err_cleared: got %b, required 0", err_at0); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL rnd_stall_stable: got %0d changes, required 0", stall_bad); end
    checks++; if (ready_bad != 0) begin errors++; $display("FAIL rnd_in_ready_busy: got %0d, required 0", ready_bad); end
    checks++; if (dup_count() != 0) begin errors++; $display("FAIL rnd_dups: got %0d, required 0", dup_count()); end
    checks++; if (n_wr != 2080) begin errors++; $display("FAIL rnd_writes: got %0d, required 2080", n_wr); end
    checks++; if (cfg_bad(CW) != 0) begin errors++; $display("FAIL rnd_cfg: got %0d bad, required 0", cfg_bad(CW)); end
    checks++;
    if (bad_bytes(32'h0010_0000, 0, 2) + bad_bytes(32'h0020_0010, 2, 2) != 0) begin
      errors++; $display("FAIL rnd_data: got %0d bad, required 0", bad_bytes(32'h0010_0000, 0, 2) + bad_bytes(32'h0020_0010, 2, 2));
    end
    checks++; if (n_hs != 4) begin errors++; $display("FAIL rnd_handshakes: got %0d, required 4", n_hs); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL rnd_done: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_reset_mid_load();
    config_region0();
    run_job(1'b0, -1, 2);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_wr_en, mem_wr_addr, mem_wr_data, busy, done, cur_region, err_addr} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got en=%b addr=%h data=%h busy=%b cur=%0d, required all 0",
               mem_wr_en, mem_wr_addr, mem_wr_data, busy, cur_region);
    end
    in_valid = 1'b0;
    #4 rst_n = 1'b1;
    config_region0();
    run_job(1'b0, -1, 0);
    checks++; if (bad_bytes(32'h0010_0000, 0, 3) != 0) begin errors++; $display("FAIL midreset_data: got %0d bad, required 0", bad_bytes(32'h0010_0000, 0, 3)); end
    checks++; if (n_wr != 2072) begin errors++; $display("FAIL midreset_writes: got %0d, required 2072", n_wr); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL midreset_done: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_start_while_busy();
    config_skip();
    run_job(1'b0, 2310, 0);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start_done: got %0d, required 1", done_cnt); end
    checks++; if (n_wr != 2080) begin errors++; $display("FAIL busy_start_writes: got %0d, required 2080", n_wr); end
    checks++; if (cfg_bad(CW) != 0) begin errors++; $display("FAIL busy_start_cfg: got %0d bad, required 0", cfg_bad(CW)); end
    checks++;
    if (bad_bytes(32'h0010_0000, 0, 2) + bad_bytes(32'h0020_0010, 2, 2) != 0) begin
      errors++; $display("FAIL busy_start_data: got %0d bad, required 0", bad_bytes(32'h0010_0000, 0, 2) + bad_bytes(32'h0020_0010, 2, 2));
    end
    checks++; if (err_addr !== 1'b1) begin errors++; $display("FAIL busy_start_err: got %b, required 1", err_addr); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cfg_only();
    test_region_load();
    test_skip_err();
    test_random_ready();
    test_reset_mid_load();
    test_start_while_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
